// File: rtl/mul8_err_monitor.sv
// Streaming error characterisation of an 8x8 approximate multiplier: accepted operands feed the multiplier, 2-stage compare vs exact, run statistics.
// Latency: a sample shows in the statistics 2 cycles after its accept edge; in_ready is derived only from state, acc and tgt.
module mul8_err_monitor #(
  parameter int CNT_W = 17,
  parameter int SAE_W = 32,
  parameter int SER_W = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] res_count,
  output logic [CNT_W-1:0] res_err_count,
  output logic [SAE_W-1:0] res_sae,
  output logic [SER_W-1:0] res_ser,
  output logic [15:0]      res_wce,
  output logic [7:0]       res_wce_a,
  output logic [7:0]       res_wce_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] acc;
  logic             accept;

  // Stage 1: operands and approximate product as captured on the accept edge.
  logic             v1;
  logic [7:0]       a1, b1;
  logic [15:0]      p1;

  // Stage 2: error terms ready for accumulation.
  logic             v2;
  logic [7:0]       a2, b2;
  logic signed [17:0] err2;
  logic [15:0]      abs2;
  logic             mis2;

  logic [15:0]        exact_s;
  logic signed [17:0] err_s;
  logic signed [17:0] neg_s;
  logic [15:0]        abs_s;

  assign mul_a    = in_a;
  assign mul_b    = in_b;
  assign in_ready = (state == RUN) && (acc < tgt);
  assign accept   = in_valid && in_ready;

  always_comb begin
    exact_s = 16'(a1) * 16'(b1);
    err_s   = $signed({2'b00, p1}) - $signed({2'b00, exact_s});
    neg_s   = -err_s;
    abs_s   = err_s[17] ? neg_s[15:0] : err_s[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      tgt           <= '0;
      acc           <= '0;
      v1            <= 1'b0;
      a1            <= '0;
      b1            <= '0;
      p1            <= '0;
      v2            <= 1'b0;
      a2            <= '0;
      b2            <= '0;
      err2          <= '0;
      abs2          <= '0;
      mis2          <= 1'b0;
      res_count     <= '0;
      res_err_count <= '0;
      res_sae       <= '0;
      res_ser       <= '0;
      res_wce       <= '0;
      res_wce_a     <= '0;
      res_wce_b     <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1  <= in_a;
        b1  <= in_b;
        p1  <= mul_o;
        acc <= acc + CNT_W'(1);
      end

      v2 <= v1;
      if (v1) begin
        a2   <= a1;
        b2   <= b1;
        err2 <= err_s;
        abs2 <= abs_s;
        mis2 <= (err_s != 18'sd0);
      end

      if (v2) begin
        res_count     <= res_count + CNT_W'(1);
        res_err_count <= res_err_count + CNT_W'(mis2);
        res_sae       <= res_sae + SAE_W'(abs2);
        res_ser       <= res_ser + SER_W'(err2);
        // Strict compare keeps the operands of the first worst-case sample.
        if (abs2 > res_wce) begin
          res_wce   <= abs2;
          res_wce_a <= a2;
          res_wce_b <= b2;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            tgt           <= cfg_count;
            acc           <= '0;
            res_count     <= '0;
            res_err_count <= '0;
            res_sae       <= '0;
            res_ser       <= '0;
            res_wce       <= '0;
            res_wce_a     <= '0;
            res_wce_b     <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            state         <= (cfg_count != '0) ? RUN : DRAIN;
          end
        end
        RUN: begin
          if (acc == tgt) state <= DRAIN;
        end
        DRAIN: begin
          if (!v1 && !v2) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_err_monitor.sv
// Directed bench for mul8_err_monitor; the bench supplies mul_o either from vectors or from a truncating approximate multiplier.
module tb_mul8_err_monitor;
  localparam int CNT_W = 17;
  localparam int SAE_W = 32;
  localparam int SER_W = 33;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] cfg_count;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a, in_b;
  logic [7:0]       mul_a, mul_b;
  logic [15:0]      mul_o;
  logic             busy, done;
  logic [CNT_W-1:0] res_count, res_err_count;
  logic [SAE_W-1:0] res_sae;
  logic [SER_W-1:0] res_ser;
  logic [15:0]      res_wce;
  logic [7:0]       res_wce_a, res_wce_b;

  logic        sweep;
  logic [15:0] drv_o;
  int          n_tests;
  int          n_fail;

  // Library-style approximate multiplier: low nibble of the product replaced by 8.
  function automatic logic [15:0] approx(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] e;
    e = 16'(a) * 16'(b);
    return {e[15:4], 4'b1000};
  endfunction

  assign mul_o = sweep ? approx(mul_a, mul_b) : drv_o;

  mul8_err_monitor #(.CNT_W(CNT_W), .SAE_W(SAE_W), .SER_W(SER_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_count(cfg_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o), .busy(busy), .done(done),
    .res_count(res_count), .res_err_count(res_err_count), .res_sae(res_sae),
    .res_ser(res_ser), .res_wce(res_wce), .res_wce_a(res_wce_a), .res_wce_b(res_wce_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] cnt);
    cfg_count = cnt;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] o);
    in_a     = a;
    in_b     = b;
    drv_o    = o;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic check_res(input string tag, input int cnt, input int errc, input longint sae,
                           input longint ser, input int wce, input int wa, input int wb);
    logic [SER_W-1:0] es;
    es = SER_W'(ser);
    check({tag, ".count"},  64'(res_count),     64'(cnt));
    check({tag, ".errcnt"}, 64'(res_err_count), 64'(errc));
    check({tag, ".sae"},    64'(res_sae),       64'(sae));
    check({tag, ".ser"},    64'(res_ser),       64'(es));
    check({tag, ".wce"},    64'(res_wce),       64'(wce));
    check({tag, ".wce_a"},  64'(res_wce_a),     64'(wa));
    check({tag, ".wce_b"},  64'(res_wce_b),     64'(wb));
  endtask

  initial begin
    int          n_acc;
    int          m_cnt, m_err;
    longint      m_sae, m_ser;
    logic [15:0] m_wce, ex, ap;
    logic [7:0]  m_a, m_b;
    longint      e;
    logic [15:0] ae;
    logic [7:0] vpat;

    n_tests  = 0;
    n_fail   = 0;
    sweep    = 1'b0;
    drv_o    = '0;
    in_a     = '0;
    in_b     = '0;

    // Reset with in_valid and start held high.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    start     = 1'b1;
    cfg_count = 17'd3;
    tick();
    tick();
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check_res("rst", 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    start    = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Basic run.
    do_start(17'd3);
    check("basic.busy", 64'(busy), 64'd1);
    send(8'd3, 8'd5, 16'd15);
    send(8'd10, 8'd10, 16'd110);
    send(8'd255, 8'd255, 16'd64000);
    wait_done("basic.done");
    check("basic.busy_end", 64'(busy), 64'd0);
    check_res("basic", 3, 2, 1035, -1015, 1025, 255, 255);

    // Backpressure and gaps; start pulses in RUN and DRAIN must be ignored.
    do_start(17'd4);
    check("bp.done_fell", 64'(done), 64'd0);
    check("bp.cleared", 64'(res_count), 64'd0);
    vpat  = 8'b1110_1101;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_a      = 8'(i + 1);
      in_b      = 8'(i + 2);
      drv_o     = 16'(i + 1) * 16'(i + 2);
      in_valid  = vpat[i];
      start     = (i == 1);
      cfg_count = 17'd7;
      if (in_valid && in_ready) n_acc++;
      tick();
      start = 1'b0;
      if (i == 5) check("bp.ready_drop", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("bp.accepts", 64'(n_acc), 64'd4);
    check("bp.in_drain", 64'(busy), 64'd1);
    cfg_count = 17'd9;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_done("bp.done");
    check_res("bp", 4, 0, 0, 0, 0, 0, 0);

    // Zero-length run: IDLE/DONE -> DRAIN -> DONE with cleared results.
    do_start(17'd0);
    check("zero.drain_busy", 64'(busy), 64'd1);
    check("zero.drain_done", 64'(done), 64'd0);
    wait_done("zero.done");
    check_res("zero", 0, 0, 0, 0, 0, 0, 0);

    // Worst-case tie keeps the first operands.
    do_start(17'd2);
    send(8'd1, 8'd1, 16'd11);
    send(8'd2, 8'd1, 16'd12);
    wait_done("tie.done");
    check_res("tie", 2, 2, 20, 20, 10, 1, 1);

    // Reset mid-run, then a fresh run.
    do_start(17'd5);
    send(8'd9, 8'd9, 16'd0);
    send(8'd8, 8'd8, 16'd100);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst.busy", 64'(busy), 64'd0);
    check("mrst.in_ready", 64'(in_ready), 64'd0);
    check_res("mrst", 0, 0, 0, 0, 0, 0, 0);
    do_start(17'd2);
    send(8'd7, 8'd3, 16'd20);
    send(8'd4, 8'd4, 16'd16);
    wait_done("fresh.done");
    check_res("fresh", 2, 1, 1, -1, 1, 7, 3);

    // Exhaustive sweep against the software model.
    m_cnt = 0; m_err = 0; m_sae = 0; m_ser = 0; m_wce = '0; m_a = '0; m_b = '0;
    for (int i = 0; i < 65536; i++) begin
      ex = 16'(i[7:0]) * 16'(i[15:8]);
      ap = approx(i[7:0], i[15:8]);
      e  = longint'(ap) - longint'(ex);
      ae = 16'(e < 0 ? -e : e);
      m_cnt++;
      if (e != 0) m_err++;
      m_sae += longint'(ae);
      m_ser += e;
      if (ae > m_wce) begin
        m_wce = ae;
        m_a   = i[7:0];
        m_b   = i[15:8];
      end
    end
    sweep = 1'b1;
    do_start(17'h10000);
    for (int i = 0; i < 65536; i++) begin
      in_a     = i[7:0];
      in_b     = i[15:8];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_done("sweep.done");
    check_res("sweep", m_cnt, m_err, m_sae, m_ser, int'(m_wce), int'(m_a), int'(m_b));
    sweep = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul8_err_monitor.md
Name: mul8_err_monitor

Overview:
- Streaming error-characterisation stage wrapped around one combinational 8x8 approximate multiplier from the library.
- Forwards each accepted operand pair to the multiplier and captures its 16-bit product in the same cycle.
- Compares the product against the exact product through a 2-stage pipeline and accumulates run statistics: sample count, mismatch count, sum of absolute error, signed error sum, worst-case error and its operands.
- Used in hardware characterisation runs of library multipliers.

Parameters:
- CNT_W, 17, width of sample counters (supports 65536 samples = exhaustive 8x8 sweep).
- SAE_W, 32, width of absolute-error accumulator.
- SER_W, 33, width of signed-error accumulator (two's complement).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; begins a run
- cfg_count  in  CNT_W  samples per run, latched on accepted start
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  8  operand A
- in_b  in  8  operand B
- mul_a  out  8  to multiplier input A; equals in_a (combinational)
- mul_b  out  8  to multiplier input B; equals in_b (combinational)
- mul_o  in  16  approximate product from multiplier (combinational return)
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- res_count  out  CNT_W  samples accumulated
- res_err_count  out  CNT_W  samples with approx != exact
- res_sae  out  SAE_W  sum of |approx - exact|
- res_ser  out  SER_W  signed sum of (approx - exact)
- res_wce  out  16  max |approx - exact|
- res_wce_a  out  8  operand A at first occurrence of res_wce
- res_wce_b  out  8  operand B at first occurrence of res_wce

Behaviour:
- Reset (rst_n=0 at clock edge):
  - State goes to IDLE.
  - All res_* outputs, busy, done and in_ready are 0; pipeline valids cleared.
  - Applies mid-run; no partial result survives.
- States and transitions:
  - IDLE:
    - start=1 → latch cfg_count into tgt, clear all res_* and the accepted counter acc.
    - Next state is RUN if cfg_count != 0, else DRAIN.
  - RUN:
    - in_ready = (acc < tgt).
    - Accept = in_valid & in_ready; each accept increments acc.
    - Once acc reaches tgt, in_ready drops on the next cycle and state goes to DRAIN.
  - DRAIN: in_ready=0; stay until both pipeline valids are 0, then go to DONE.
  - DONE:
    - done=1; results held stable.
    - start=1 starts a new run exactly as from IDLE, and done falls the next cycle.
- start in RUN or DRAIN is ignored. There is no abort; only rst_n stops a run.
- Pipeline:
  - S1 (accept edge): register a, b, p=mul_o, v1=1.
  - S2: exact = a*b (16 bit, unsigned); err = p - exact as 18-bit signed; abs = |err| as 16 bit (max 65535); mis = (err != 0). Register with v2=v1.
  - Accumulate (edge after S2, when v2=1):
    - res_count += 1
    - res_err_count += mis
    - res_sae += abs
    - res_ser += sign-extended err
    - if abs > res_wce (strictly greater): update res_wce, res_wce_a, res_wce_b
  - Statistics reflect a sample 2 cycles after its accept edge. done asserts no earlier than 1 cycle after the final accumulate.
- Throughput is 1 sample/cycle; in_valid gaps are allowed and create pipeline bubbles.
- Width rules:
  - Accumulators are sized so no overflow occurs for ≤65536 samples; no saturation logic.
  - res_ser worst case is ±65535·65536, which fits 33-bit signed.
- in_ready depends only on state, acc and tgt, never on in_valid.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and start=1 → in_ready=0, busy=0, done=0, all res_* = 0.
- Basic run, with the bench model driving mul_o: start, cfg_count=3; pairs (3,5,mul_o=15), (10,10,mul_o=110), (255,255,mul_o=64000) → res_count=3, res_err_count=2, res_sae=1035, res_ser=-1015, res_wce=1025, wce_a=255, wce_b=255, done high.
- Backpressure and gaps: cfg_count=4; in_valid toggles 1,0,1,1,0,1,1,1 → exactly 4 accepts; in_ready low the cycle after the 4th accept; extra valids ignored; res_count=4.
- Boundaries:
  - cfg_count=0 → IDLE→DRAIN→DONE with all res_* = 0.
  - WCE tie: (1,1,mul_o=11) then (2,1,mul_o=12), both |err|=10 → wce operands stay (1,1).
- Exhaustive sweep with a library approximate multiplier instance: cfg_count=65536, a=i[7:0], b=i[15:8] → every res_* field matches the bit-accurate software model; res_count=65536.
- Control robustness:
  - start pulses during RUN and DRAIN → no effect.
  - rst_n=0 mid-RUN → all cleared; a new start then gives correct results for a fresh cfg_count=2 run.
